rs_station: RTL and testbench
=============================

# rs_station

Reservation station for the ALU path of the out-of-order core. It accepts non-load/store instructions dispatched by the reorder buffer and holds each one until both source operands are available. Operands are woken up by matching the ROB commit broadcast (tag = producer PC). Ready entries are issued one per cycle to the ALU, and the whole station is flushed on a ROB exception.

## Interface
- RsSize, 8: number of entries.
- IdxLength, 2: entry index width minus one (log2(RsSize)-1).
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- is_empty_from_rob  in  1  1 = no dispatch this cycle.
- is_sl_from_rob  in  1  1 = dispatched op belongs to the SLB; the RS ignores it.
- pc_from_rob  in  32  instruction PC; also the instruction's tag.
- op_from_rob  in  6  opcode.
- v1_from_rob, v2_from_rob  in  32 each  operand values.
- q1_from_rob, q2_from_rob  in  32 each  producer tags; NoTag = operand already valid.
- imm_from_rob  in  32  immediate.
- is_commit_from_rob  in  1  commit broadcast valid.
- commit_pc_from_rob  in  32  committing tag.
- commit_data_from_rob  in  32  committed value.
- is_exception_from_rob  in  1  flush request.
- is_stall_from_alu  in  1  ALU cannot accept this cycle.
- is_stall_to_rob  out  1  registered almost-full.
- is_valid_to_alu  out  1  issue valid.
- op_to_alu  out  6; pc_to_alu, v1_to_alu, v2_to_alu, imm_to_alu  out  32 each  issued instruction.

## Operation
- Each entry holds: valid, op, pc, imm, v1, q1, v2, q2.
- Dispatch accept condition: is_empty_from_rob=0, is_sl_from_rob=0 and a free entry exists. The entry is written into the lowest-index free slot.
- Dispatch with no free slot is a protocol violation; the RS drops the instruction.
- Dispatch capture: if is_commit_from_rob=1 and commit_pc_from_rob equals an incoming q, the RS stores commit_data_from_rob and sets q=NoTag in the same edge.
- Wake-up: for every valid entry, a q matching commit_pc_from_rob (with commit valid) takes commit_data into v and q becomes NoTag. q1 and q2 are checked independently.
- Ready condition: valid, q1=NoTag and q2=NoTag.
- Issue register:
  - A transfer occurs on an edge where is_valid_to_alu=1 and is_stall_from_alu=0.
  - When the register is empty or transferring, the RS loads the lowest-index ready entry, frees that entry and sets is_valid_to_alu. If no entry is ready, is_valid_to_alu=0.
  - While is_stall_from_alu=1 with valid held, all issue outputs hold unchanged.
- is_stall_to_rob is registered from the next-state free count: 1 when free entries < 2. This gives one cycle of slack for a dispatch already in flight.
- Flush: is_exception_from_rob=1 at an edge does the following:
  - clears every valid bit and is_valid_to_alu;
  - clears is_stall_to_rob;
  - ignores dispatch and commit in that cycle.
  - Flush has priority over all other events.
- Simultaneous dispatch, wake-up and issue in one edge are all performed. A freshly dispatched entry is not issue-eligible until the following edge.
- Reset (rst low, asynchronous): all valid=0, and every output is 0.

## Timing
- Dispatch at edge N with ready operands: earliest is_valid_to_alu=1 after edge N+1.
- Last operand committed at edge C:
  - with RS_FORWARD_EN: issue after edge C;
  - without it: issue after edge C+1.
- Issue throughput: 1 per cycle.
- Free count is updated at the same edge as dispatch and issue.
- Flush latency: 1 edge. After that edge the station is empty and dispatch is accepted on the next edge.

## Configuration
- RS_FORWARD_EN defined: issue selection uses post-wake-up readiness combinationally. The issued v1/v2 take commit_data directly when their tag matches the broadcast in that cycle.
- RS_FORWARD_EN undefined: selection uses only registered readiness. Slower, but keeps the shorter critical path.

## Structure
- Shared package (parameters.v): DataLength, PcLength, OpcodeLength, NoTag (32'hFFFFFFFF), True/False, and the opcode constants used by the SLB filter.
- One sub-module, rs_select: a priority encoder returning the lowest set index plus a found flag. It is instantiated twice: once for the free-slot search and once for the ready-entry search.

## Test plan
- Reset mid-stream: assert rst low with 3 entries valid → is_valid_to_alu=0 and is_stall_to_rob=0 immediately; no issue after release.
- Ready dispatch: op ADD, pc=0x10, v1=5, v2=7, q1=q2=NoTag → issue after the next edge with pc_to_alu=0x10, v1=5, v2=7.
- Wake-up:
  - Setup: dispatch pc=0x20 with q1=0x14; later commit pc=0x14, data=0xAB.
  - Required response: issue with v1=0xAB, one edge after the commit with RS_FORWARD_EN, two edges without it.
- Same-cycle capture: dispatch q2=0x30 while commit pc=0x30, data=9 → entry stored ready; issues next edge with v2=9.
- Fill and stall:
  - Setup: hold is_stall_from_alu=1 and dispatch 8 ready ops.
  - Required response: is_stall_to_rob rises once 7 slots are used; outputs hold the first op.
  - Release the stall → ops issue in index order, one per cycle.
- Flush: 5 entries valid plus a dispatch in the same cycle as is_exception_from_rob=1 → all cleared, is_valid_to_alu=0 next cycle, the dispatched op is never issued.

Source files
------------

// File: rtl/rs_station_pkg.sv
// Shared types and constants for the ALU reservation station.
package rs_station_pkg;

  localparam int DataLength   = 32;
  localparam int PcLength     = 32;
  localparam int OpcodeLength = 6;

  localparam logic [PcLength-1:0] NoTag = 32'hFFFFFFFF;
  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  localparam logic [OpcodeLength-1:0] OpAdd   = 6'h01;
  localparam logic [OpcodeLength-1:0] OpSub   = 6'h02;
  localparam logic [OpcodeLength-1:0] OpLoad  = 6'h20;
  localparam logic [OpcodeLength-1:0] OpStore = 6'h28;

  typedef struct packed {
    logic [OpcodeLength-1:0] op;
    logic [PcLength-1:0]     pc;
    logic [DataLength-1:0]   imm;
    logic [DataLength-1:0]   v1;
    logic [PcLength-1:0]     q1;
    logic [DataLength-1:0]   v2;
    logic [PcLength-1:0]     q2;
  } rs_entry_t;

endpackage

// File: rtl/rs_station_select.sv
// Lowest-index priority encoder with a found flag.
module rs_station_select #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_station.sv
// ALU reservation station: dispatch, commit wake-up, in-order-by-index issue, flush.
// Optional RS_FORWARD_EN lets a same-cycle commit make an entry issuable.
module rs_station
  import rs_station_pkg::*;
#(
  parameter int RsSize    = 8,
  parameter int IdxLength = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    is_empty_from_rob,
  input  logic                    is_sl_from_rob,
  input  logic [PcLength-1:0]     pc_from_rob,
  input  logic [OpcodeLength-1:0] op_from_rob,
  input  logic [DataLength-1:0]   v1_from_rob,
  input  logic [DataLength-1:0]   v2_from_rob,
  input  logic [PcLength-1:0]     q1_from_rob,
  input  logic [PcLength-1:0]     q2_from_rob,
  input  logic [DataLength-1:0]   imm_from_rob,
  input  logic                    is_commit_from_rob,
  input  logic [PcLength-1:0]     commit_pc_from_rob,
  input  logic [DataLength-1:0]   commit_data_from_rob,
  input  logic                    is_exception_from_rob,
  input  logic                    is_stall_from_alu,
  output logic                    is_stall_to_rob,
  output logic                    is_valid_to_alu,
  output logic [OpcodeLength-1:0] op_to_alu,
  output logic [PcLength-1:0]     pc_to_alu,
  output logic [DataLength-1:0]   v1_to_alu,
  output logic [DataLength-1:0]   v2_to_alu,
  output logic [DataLength-1:0]   imm_to_alu
);

  localparam int IW = IdxLength + 1;

  rs_entry_t             ent_p0 [RsSize];
  logic [RsSize-1:0]     vld_p0, vld_nxt, hit1, hit2, rdy_req;
  logic [IW-1:0]         free_idx, rdy_idx;
  logic                  free_found, rdy_found;
  logic                  dispatch_en, load_en, issue_en, stall_nxt;
  logic [DataLength-1:0] iss_v1, iss_v2, cap_v1, cap_v2;
  logic [PcLength-1:0]   cap_q1, cap_q2;

  // A NoTag operand never matches, even if the broadcast tag happens to equal NoTag.
  function automatic logic tag_hit(input logic [PcLength-1:0] q, input logic cvld,
                                   input logic [PcLength-1:0] cpc);
    return cvld && (q != NoTag) && (q == cpc);
  endfunction

  always_comb begin
    hit1    = '0;
    hit2    = '0;
    rdy_req = '0;
    for (int i = 0; i < RsSize; i++) begin
      hit1[i] = tag_hit(ent_p0[i].q1, is_commit_from_rob, commit_pc_from_rob);
      hit2[i] = tag_hit(ent_p0[i].q2, is_commit_from_rob, commit_pc_from_rob);
`ifdef RS_FORWARD_EN
      rdy_req[i] = vld_p0[i] && ((ent_p0[i].q1 == NoTag) || hit1[i])
                             && ((ent_p0[i].q2 == NoTag) || hit2[i]);
`else
      rdy_req[i] = vld_p0[i] && (ent_p0[i].q1 == NoTag) && (ent_p0[i].q2 == NoTag);
`endif
    end
  end

  rs_station_select #(.N(RsSize), .IW(IW)) u_free_sel (
    .req   (~vld_p0),
    .idx   (free_idx),
    .found (free_found)
  );

  rs_station_select #(.N(RsSize), .IW(IW)) u_rdy_sel (
    .req   (rdy_req),
    .idx   (rdy_idx),
    .found (rdy_found)
  );

  always_comb begin
    dispatch_en = !is_empty_from_rob && !is_sl_from_rob && free_found;
    load_en     = !is_valid_to_alu || !is_stall_from_alu;
    issue_en    = load_en && rdy_found;

    vld_nxt = vld_p0;
    if (issue_en)    vld_nxt[rdy_idx]  = False;
    if (dispatch_en) vld_nxt[free_idx] = True;
    if (is_exception_from_rob) vld_nxt = '0;
    stall_nxt = $countones(vld_nxt) > (RsSize - 2);

    cap_v1 = v1_from_rob;
    cap_q1 = q1_from_rob;
    if (tag_hit(q1_from_rob, is_commit_from_rob, commit_pc_from_rob)) begin
      cap_v1 = commit_data_from_rob;
      cap_q1 = NoTag;
    end
    cap_v2 = v2_from_rob;
    cap_q2 = q2_from_rob;
    if (tag_hit(q2_from_rob, is_commit_from_rob, commit_pc_from_rob)) begin
      cap_v2 = commit_data_from_rob;
      cap_q2 = NoTag;
    end

    iss_v1 = ent_p0[rdy_idx].v1;
    iss_v2 = ent_p0[rdy_idx].v2;
`ifdef RS_FORWARD_EN
    if (hit1[rdy_idx]) iss_v1 = commit_data_from_rob;
    if (hit2[rdy_idx]) iss_v2 = commit_data_from_rob;
`endif
  end

  // Stage p0 -> p1: entry table bookkeeping and the issue register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0          <= '0;
      is_stall_to_rob <= False;
      is_valid_to_alu <= False;
      op_to_alu       <= '0;
      pc_to_alu       <= '0;
      v1_to_alu       <= '0;
      v2_to_alu       <= '0;
      imm_to_alu      <= '0;
    end else begin
      vld_p0          <= vld_nxt;
      is_stall_to_rob <= stall_nxt;
      if (is_exception_from_rob) begin
        is_valid_to_alu <= False;
      end else if (load_en) begin
        is_valid_to_alu <= rdy_found;
        if (rdy_found) begin
          op_to_alu  <= ent_p0[rdy_idx].op;
          pc_to_alu  <= ent_p0[rdy_idx].pc;
          imm_to_alu <= ent_p0[rdy_idx].imm;
          v1_to_alu  <= iss_v1;
          v2_to_alu  <= iss_v2;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!is_exception_from_rob) begin
      for (int i = 0; i < RsSize; i++) begin
        if (vld_p0[i] && hit1[i]) begin
          ent_p0[i].v1 <= commit_data_from_rob;
          ent_p0[i].q1 <= NoTag;
        end
        if (vld_p0[i] && hit2[i]) begin
          ent_p0[i].v2 <= commit_data_from_rob;
          ent_p0[i].q2 <= NoTag;
        end
      end
      if (dispatch_en) begin
        ent_p0[free_idx] <= '{op: op_from_rob, pc: pc_from_rob, imm: imm_from_rob,
                              v1: cap_v1, q1: cap_q1, v2: cap_v2, q2: cap_q2};
      end
    end
  end

endmodule

// File: tb/tb_rs_station.sv
// Directed bench for rs_station with a slot-array reference model and per-cycle compare.
module tb_rs_station;
  import rs_station_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_empty_from_rob, is_sl_from_rob;
  logic [31:0] pc_from_rob, v1_from_rob, v2_from_rob, q1_from_rob, q2_from_rob, imm_from_rob;
  logic [5:0]  op_from_rob;
  logic        is_commit_from_rob;
  logic [31:0] commit_pc_from_rob, commit_data_from_rob;
  logic        is_exception_from_rob, is_stall_from_alu;
  logic        is_stall_to_rob, is_valid_to_alu;
  logic [5:0]  op_to_alu;
  logic [31:0] pc_to_alu, v1_to_alu, v2_to_alu, imm_to_alu;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  rs_station dut (
    .clk(clk), .rst(rst),
    .is_empty_from_rob(is_empty_from_rob), .is_sl_from_rob(is_sl_from_rob),
    .pc_from_rob(pc_from_rob), .op_from_rob(op_from_rob),
    .v1_from_rob(v1_from_rob), .v2_from_rob(v2_from_rob),
    .q1_from_rob(q1_from_rob), .q2_from_rob(q2_from_rob), .imm_from_rob(imm_from_rob),
    .is_commit_from_rob(is_commit_from_rob), .commit_pc_from_rob(commit_pc_from_rob),
    .commit_data_from_rob(commit_data_from_rob),
    .is_exception_from_rob(is_exception_from_rob), .is_stall_from_alu(is_stall_from_alu),
    .is_stall_to_rob(is_stall_to_rob), .is_valid_to_alu(is_valid_to_alu),
    .op_to_alu(op_to_alu), .pc_to_alu(pc_to_alu), .v1_to_alu(v1_to_alu),
    .v2_to_alu(v2_to_alu), .imm_to_alu(imm_to_alu)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: a bag of 8 slots plus the one-deep issue register.
  bit          m_vld [8];
  logic [5:0]  m_op  [8];
  logic [31:0] m_pc [8], m_imm [8], m_v1 [8], m_q1 [8], m_v2 [8], m_q2 [8];
  bit          e_vld, e_stall;
  logic [5:0]  e_op;
  logic [31:0] e_pc, e_v1, e_v2, e_imm;
  int          slot, pick, used;

  function automatic bit bcast(input logic [31:0] q);
    return is_commit_from_rob && q != NoTag && q == commit_pc_from_rob;
  endfunction

  function automatic bit operand_ok(input logic [31:0] q);
`ifdef RS_FORWARD_EN
    return q == NoTag || bcast(q);
`else
    return q == NoTag;
`endif
  endfunction

  function automatic logic [31:0] operand_val(input logic [31:0] q, input logic [31:0] v);
`ifdef RS_FORWARD_EN
    if (bcast(q)) return commit_data_from_rob;
`endif
    return v;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst || is_exception_from_rob) begin
      for (int i = 0; i < 8; i++) m_vld[i] = 1'b0;
      e_vld   = 1'b0;
      e_stall = 1'b0;
    end else begin
      slot = -1;
      for (int i = 0; i < 8; i++) if (!m_vld[i] && slot < 0) slot = i;
      if (!e_vld || !is_stall_from_alu) begin
        pick = -1;
        for (int i = 0; i < 8; i++)
          if (pick < 0 && m_vld[i] && operand_ok(m_q1[i]) && operand_ok(m_q2[i])) pick = i;
        e_vld = (pick >= 0);
        if (pick >= 0) begin
          e_op  = m_op[pick];
          e_pc  = m_pc[pick];
          e_imm = m_imm[pick];
          e_v1  = operand_val(m_q1[pick], m_v1[pick]);
          e_v2  = operand_val(m_q2[pick], m_v2[pick]);
          m_vld[pick] = 1'b0;
        end
      end
      for (int i = 0; i < 8; i++) begin
        if (m_vld[i] && bcast(m_q1[i])) begin m_v1[i] = commit_data_from_rob; m_q1[i] = NoTag; end
        if (m_vld[i] && bcast(m_q2[i])) begin m_v2[i] = commit_data_from_rob; m_q2[i] = NoTag; end
      end
      if (!is_empty_from_rob && !is_sl_from_rob && slot >= 0) begin
        m_vld[slot] = 1'b1;
        m_op[slot]  = op_from_rob;
        m_pc[slot]  = pc_from_rob;
        m_imm[slot] = imm_from_rob;
        m_v1[slot]  = bcast(q1_from_rob) ? commit_data_from_rob : v1_from_rob;
        m_q1[slot]  = bcast(q1_from_rob) ? NoTag : q1_from_rob;
        m_v2[slot]  = bcast(q2_from_rob) ? commit_data_from_rob : v2_from_rob;
        m_q2[slot]  = bcast(q2_from_rob) ? NoTag : q2_from_rob;
      end
      used = 0;
      for (int i = 0; i < 8; i++) if (m_vld[i]) used++;
      e_stall = (8 - used) < 2;
    end
  end

  always @(negedge clk) begin
    if (rst && chk_en) begin
      chk("model_valid", {31'd0, is_valid_to_alu}, {31'd0, e_vld});
      chk("model_stall", {31'd0, is_stall_to_rob}, {31'd0, e_stall});
      if (e_vld) begin
        chk("model_op",  {26'd0, op_to_alu}, {26'd0, e_op});
        chk("model_pc",  pc_to_alu,  e_pc);
        chk("model_v1",  v1_to_alu,  e_v1);
        chk("model_v2",  v2_to_alu,  e_v2);
        chk("model_imm", imm_to_alu, e_imm);
      end
    end
  end

  task automatic idle();
    is_empty_from_rob     = 1'b1;
    is_sl_from_rob        = 1'b0;
    pc_from_rob           = '0;
    op_from_rob           = '0;
    v1_from_rob           = '0;
    v2_from_rob           = '0;
    q1_from_rob           = NoTag;
    q2_from_rob           = NoTag;
    imm_from_rob          = '0;
    is_commit_from_rob    = 1'b0;
    commit_pc_from_rob    = '0;
    commit_data_from_rob  = '0;
    is_exception_from_rob = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    idle();
  endtask

  task automatic dispatch(input logic [31:0] pc, input logic [31:0] v1, input logic [31:0] q1,
                          input logic [31:0] v2, input logic [31:0] q2, input logic [31:0] imm);
    is_empty_from_rob = 1'b0;
    op_from_rob       = OpAdd;
    pc_from_rob       = pc;
    v1_from_rob       = v1;
    q1_from_rob       = q1;
    v2_from_rob       = v2;
    q2_from_rob       = q2;
    imm_from_rob      = imm;
  endtask

  task automatic commit(input logic [31:0] tag, input logic [31:0] data);
    is_commit_from_rob   = 1'b1;
    commit_pc_from_rob   = tag;
    commit_data_from_rob = data;
  endtask

  int drain_order [7] = '{2, 1, 3, 4, 5, 6, 7};
  bit got;

  initial begin
    rst = 1'b0;
    is_stall_from_alu = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    chk("reset_valid", {31'd0, is_valid_to_alu}, 32'd0);
    chk("reset_stall", {31'd0, is_stall_to_rob}, 32'd0);
    chk("reset_pc", pc_to_alu, 32'd0);
    rst = 1'b1;
    chk_en = 1'b1;

    // ready dispatch
    step(); dispatch(32'h10, 32'd5, NoTag, 32'd7, NoTag, 32'h3);
    step(); chk("ready_early", {31'd0, is_valid_to_alu}, 32'd0);
    step(); chk("ready_valid", {31'd0, is_valid_to_alu}, 32'd1);
    chk("ready_pc", pc_to_alu, 32'h10);
    chk("ready_v1", v1_to_alu, 32'd5);
    chk("ready_v2", v2_to_alu, 32'd7);
    step(); chk("ready_once", {31'd0, is_valid_to_alu}, 32'd0);

    // SLB ops are ignored
    step(); dispatch(32'h60, 32'd1, NoTag, 32'd1, NoTag, 32'd0); is_sl_from_rob = 1'b1;
    step(); step(); chk("sl_ignored", {31'd0, is_valid_to_alu}, 32'd0);

    // wake-up through the commit broadcast
    step(); dispatch(32'h20, 32'd0, 32'h14, 32'd3, NoTag, 32'd1);
    step(); step(); chk("wake_wait", {31'd0, is_valid_to_alu}, 32'd0);
    commit(32'h14, 32'hAB);
    step();
`ifdef RS_FORWARD_EN
    chk("wake_valid", {31'd0, is_valid_to_alu}, 32'd1);
    chk("wake_v1", v1_to_alu, 32'hAB);
`else
    chk("wake_not_yet", {31'd0, is_valid_to_alu}, 32'd0);
    step();
    chk("wake_valid", {31'd0, is_valid_to_alu}, 32'd1);
    chk("wake_v1", v1_to_alu, 32'hAB);
`endif
    chk("wake_pc", pc_to_alu, 32'h20);
    step();

    // q1 and q2 woken independently, q2 first
    step(); dispatch(32'h70, 32'd0, 32'h50, 32'd0, 32'h54, 32'd0);
    step(); commit(32'h54, 32'h22);
    step(); commit(32'h50, 32'h11);
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      step();
      if (is_valid_to_alu) got = 1'b1;
    end
    chk("both_seen", {31'd0, got}, 32'd1);
    if (got) begin
      chk("both_v1", v1_to_alu, 32'h11);
      chk("both_v2", v2_to_alu, 32'h22);
    end
    step(); step();

    // same-cycle capture at dispatch
    step(); dispatch(32'h40, 32'd1, NoTag, 32'd0, 32'h30, 32'd0); commit(32'h30, 32'd9);
    step(); chk("cap_early", {31'd0, is_valid_to_alu}, 32'd0);
    step(); chk("cap_valid", {31'd0, is_valid_to_alu}, 32'd1);
    chk("cap_v2", v2_to_alu, 32'd9);
    step();

    // fill under ALU stall, then drain
    is_stall_from_alu = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(); dispatch(32'h100 + 32'(4 * i), 32'(i), NoTag, 32'h10 + 32'(i), NoTag, 32'(i));
    end
    step(); chk("fill_stall_rob", {31'd0, is_stall_to_rob}, 32'd1);
    chk("fill_hold_pc", pc_to_alu, 32'h100);
    step(); chk("fill_hold_pc2", pc_to_alu, 32'h100);
    chk("fill_hold_valid", {31'd0, is_valid_to_alu}, 32'd1);
    is_stall_from_alu = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      chk("drain_pc", pc_to_alu, 32'h100 + 32'(4 * drain_order[k]));
    end
    step(); chk("drain_done", {31'd0, is_valid_to_alu}, 32'd0);

    // flush with a dispatch in the same cycle
    is_stall_from_alu = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(); dispatch(32'h200 + 32'(4 * i), 32'(i), NoTag, 32'd0, NoTag, 32'd0);
    end
    step(); dispatch(32'h300, 32'd1, NoTag, 32'd1, NoTag, 32'd0); is_exception_from_rob = 1'b1;
    step(); chk("flush_valid", {31'd0, is_valid_to_alu}, 32'd0);
    chk("flush_stall", {31'd0, is_stall_to_rob}, 32'd0);
    is_stall_from_alu = 1'b0;
    repeat (3) step();
    chk("flush_empty", {31'd0, is_valid_to_alu}, 32'd0);
    dispatch(32'h50, 32'd2, NoTag, 32'd4, NoTag, 32'd0);
    step(); step(); chk("post_flush_pc", pc_to_alu, 32'h50);
    step();

    // asynchronous reset mid-stream
    is_stall_from_alu = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); dispatch(32'h400 + 32'(4 * i), 32'(i), NoTag, 32'd0, NoTag, 32'd0);
    end
    step();
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, is_valid_to_alu}, 32'd0);
    chk("rst_mid_stall", {31'd0, is_stall_to_rob}, 32'd0);
    chk("rst_mid_pc", pc_to_alu, 32'd0);
    step(); step();
    is_stall_from_alu = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    chk("rst_no_issue", {31'd0, is_valid_to_alu}, 32'd0);

    step();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
